ipv4_local_lut_arbiter: RTL and testbench

- Shares the single destination-address lookup port of the IPv4 local-address LUT between NUM_REQ requesters, e.g. per-port header parsers.
- Grants one requester at a time in round-robin order and keeps exactly one lookup in flight.
- Waits a fixed LUT_LATENCY window, then returns the is_local verdict to the granted requester.
- Keeps lookup and hit statistics for the register interface.

---
 rtl/ipv4_local_lut_arbiter.sv | 138 +++++++++++++
 tb/tb_ipv4_local_lut_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ipv4_local_lut_arbiter.sv
// Round-robin arbiter sharing the IPv4 local-address LUT lookup port.
// One lookup in flight; verdict returned after a fixed LUT window.
module ipv4_local_lut_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int REQ_IDX_BITS = 2,
  parameter int LUT_LATENCY  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      i_req_valid,
  input  logic [NUM_REQ*32-1:0]   i_req_daddr,
  output logic [NUM_REQ-1:0]      o_req_ack,
  output logic [NUM_REQ-1:0]      o_rsp_valid,
  output logic                    o_rsp_is_local,
  output logic [31:0]             o_lut_daddr,
  output logic                    o_lut_daddr_valid,
  input  logic                    i_lut_is_local,
  input  logic                    i_lut_is_local_valid,
  input  logic                    i_stats_clear,
  output logic                    o_busy,
  output logic [31:0]             o_lookup_count,
  output logic [31:0]             o_local_hit_count
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(LUT_LATENCY - 1);

  state_t                  state;
  logic [REQ_IDX_BITS-1:0] rr_ptr;
  logic [REQ_IDX_BITS-1:0] gnt;
  logic [REQ_IDX_BITS-1:0] pick;
  logic                    pick_any;
  logic                    hit;
  logic [3:0]              cnt;
  logic                    lut_hit;
  logic                    resp_local;
  logic [31:0]             daddr [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign daddr[k] = i_req_daddr[32*k +: 32];
  end

  function automatic logic [REQ_IDX_BITS-1:0] wrap_idx(
    input logic [REQ_IDX_BITS-1:0] base,
    input int                      off
  );
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return REQ_IDX_BITS'(s);
  endfunction

  // Scan downward so the slot closest to rr_ptr is the last (winning) write.
  always_comb begin
    pick_any = 1'b0;
    pick     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (i_req_valid[wrap_idx(rr_ptr, i)]) begin
        pick_any = 1'b1;
        pick     = wrap_idx(rr_ptr, i);
      end
    end
  end

  assign lut_hit        = i_lut_is_local_valid & i_lut_is_local;
  assign resp_local     = hit | lut_hit;
  assign o_rsp_is_local = (state == RESP) & resp_local;
  assign o_busy         = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      rr_ptr            <= '0;
      gnt               <= '0;
      hit               <= 1'b0;
      cnt               <= '0;
      o_req_ack         <= '0;
      o_rsp_valid       <= '0;
      o_lut_daddr       <= '0;
      o_lut_daddr_valid <= 1'b0;
    end else begin
      o_req_ack         <= '0;
      o_rsp_valid       <= '0;
      o_lut_daddr_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_any) begin
            gnt               <= pick;
            o_lut_daddr       <= daddr[pick];
            o_req_ack         <= NUM_REQ'(1) << pick;
            o_lut_daddr_valid <= 1'b1;
            hit               <= 1'b0;
            cnt               <= '0;
            state             <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt + 4'd1;
          if (lut_hit) hit <= 1'b1;
          if (cnt == CNT_LAST) begin
            o_rsp_valid <= NUM_REQ'(1) << gnt;
            state       <= RESP;
          end
        end
        RESP: begin
          rr_ptr <= wrap_idx(gnt, 1);
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A late LUT strobe in RESP still lands in the verdict and the hit count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_lookup_count    <= '0;
      o_local_hit_count <= '0;
    end else if (i_stats_clear) begin
      o_lookup_count    <= '0;
      o_local_hit_count <= '0;
    end else if (state == RESP) begin
      o_lookup_count <= o_lookup_count + 32'd1;
      if (resp_local) o_local_hit_count <= o_local_hit_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_ipv4_local_lut_arbiter.sv
// Directed bench for ipv4_local_lut_arbiter with a response scoreboard.
// Inputs move on negedge; outputs are sampled on negedge (monitor at +2).
module tb_ipv4_local_lut_arbiter;

  logic         clk;
  logic         reset;
  logic [3:0]   req_valid;
  logic [127:0] req_daddr;
  logic [3:0]   o_req_ack;
  logic [3:0]   o_rsp_valid;
  logic         o_rsp_is_local;
  logic [31:0]  o_lut_daddr;
  logic         o_lut_daddr_valid;
  logic         lut_local;
  logic         lut_valid;
  logic         stats_clear;
  logic         o_busy;
  logic [31:0]  o_lookup_count;
  logic [31:0]  o_local_hit_count;

  ipv4_local_lut_arbiter #(
    .NUM_REQ(4),
    .REQ_IDX_BITS(2),
    .LUT_LATENCY(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .i_req_valid(req_valid),
    .i_req_daddr(req_daddr),
    .o_req_ack(o_req_ack),
    .o_rsp_valid(o_rsp_valid),
    .o_rsp_is_local(o_rsp_is_local),
    .o_lut_daddr(o_lut_daddr),
    .o_lut_daddr_valid(o_lut_daddr_valid),
    .i_lut_is_local(lut_local),
    .i_lut_is_local_valid(lut_valid),
    .i_stats_clear(stats_clear),
    .o_busy(o_busy),
    .o_lookup_count(o_lookup_count),
    .o_local_hit_count(o_local_hit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] oh;
    logic       loc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_lookups = 0;
  logic [31:0] exp_hits = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Scoreboard monitor: every response pulse must match the next queued entry.
  always begin
    @(negedge clk);
    #2;
    if (|o_rsp_valid) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", {60'd0, o_rsp_valid}, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_idx", {60'd0, o_rsp_valid}, {60'd0, mon_e.oh});
        chk("rsp_local", {63'd0, o_rsp_is_local}, {63'd0, mon_e.loc});
      end
    end else begin
      chk("rsp_local_idle", {63'd0, o_rsp_is_local}, 64'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Caller is at a negedge with the DUT in IDLE. hit_at picks the negedge
  // (1=ISSUE .. 4=RESP) at which the LUT strobes local for one cycle.
  task automatic do_lookup(input int idx, input logic [31:0] addr,
                           input int hit_at, input bit loc, input bit clr);
    logic [3:0] oh;
    exp_t       e;
    oh = 4'b0001 << idx;
    e.oh = oh;
    e.loc = loc;
    sb.push_back(e);
    req_daddr[32*idx +: 32] = addr;
    req_valid[idx] = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      lut_valid = 1'b0;
      lut_local = 1'b0;
      stats_clear = 1'b0;
      if (n == 1) begin
        chk("ack", {60'd0, o_req_ack}, {60'd0, oh});
        chk("lut_daddr", {32'd0, o_lut_daddr}, {32'd0, addr});
        chk("strobe", {63'd0, o_lut_daddr_valid}, 64'd1);
        req_valid[idx] = 1'b0;
      end else if (n < 4) begin
        chk("strobe_off", {63'd0, o_lut_daddr_valid}, 64'd0);
        chk("rsp_early", {60'd0, o_rsp_valid}, 64'd0);
        chk("busy", {63'd0, o_busy}, 64'd1);
      end else if (n == 4) begin
        chk("rsp_time", {60'd0, o_rsp_valid}, {60'd0, oh});
        stats_clear = clr;
      end else begin
        exp_lookups = exp_lookups + 32'd1;
        if (loc) exp_hits = exp_hits + 32'd1;
        if (clr) begin
          exp_lookups = 0;
          exp_hits = 0;
        end
        chk("lookup_cnt", {32'd0, o_lookup_count}, {32'd0, exp_lookups});
        chk("hit_cnt", {32'd0, o_local_hit_count}, {32'd0, exp_hits});
        chk("daddr_hold", {32'd0, o_lut_daddr}, {32'd0, addr});
        chk("idle", {63'd0, o_busy}, 64'd0);
      end
      if (n == hit_at) begin
        lut_valid = 1'b1;
        lut_local = 1'b1;
      end
    end
  endtask

  logic [3:0] exp_oh [5];
  int         g;
  int         last;

  initial begin
    reset = 1'b1;
    req_valid = '0;
    req_daddr = '0;
    lut_valid = 1'b0;
    lut_local = 1'b0;
    stats_clear = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {63'd0, o_busy}, 64'd0);
    chk("rst_ack", {60'd0, o_req_ack}, 64'd0);
    chk("rst_daddr", {32'd0, o_lut_daddr}, 64'd0);
    chk("rst_lookups", {32'd0, o_lookup_count}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Basic local hit one cycle after the strobe.
    do_lookup(1, 32'h0A00_0001, 2, 1'b1, 1'b0);

    // rr_ptr is 2: requesters 0 and 3 must go 3 then 0.
    exp_oh[0] = 4'b1000;
    exp_oh[1] = 4'b0001;
    sb.push_back('{oh: 4'b1000, loc: 1'b0});
    sb.push_back('{oh: 4'b0001, loc: 1'b0});
    req_daddr[31:0] = 32'h0A00_0010;
    req_daddr[127:96] = 32'h0A00_0013;
    req_valid = 4'b1001;
    g = 0;
    for (int c = 0; c < 30 && g < 2; c++) begin
      @(negedge clk);
      if (|o_req_ack) begin
        chk("rr_grant", {60'd0, o_req_ack}, {60'd0, exp_oh[g]});
        req_valid = req_valid & ~o_req_ack;
        g++;
      end
    end
    if (g < 2) chk("rr_timeout", g, 2);
    req_valid = '0;
    repeat (4) @(negedge clk);
    exp_lookups = exp_lookups + 32'd2;

    // No strobe at all, then a strobe during ISSUE that must be ignored.
    do_lookup(2, 32'hC0A8_0102, 0, 1'b0, 1'b0);
    do_lookup(3, 32'hC0A8_0103, 1, 1'b0, 1'b0);

    // All four requesters held: 0,1,2,3,0 spaced five cycles apart.
    exp_oh[0] = 4'b0001;
    exp_oh[1] = 4'b0010;
    exp_oh[2] = 4'b0100;
    exp_oh[3] = 4'b1000;
    exp_oh[4] = 4'b0001;
    for (int k = 0; k < 5; k++) sb.push_back('{oh: exp_oh[k], loc: 1'b0});
    req_valid = 4'b1111;
    g = 0;
    last = 0;
    for (int c = 0; c < 60 && g < 5; c++) begin
      @(negedge clk);
      if (|o_req_ack) begin
        chk("all_grant", {60'd0, o_req_ack}, {60'd0, exp_oh[g]});
        if (g > 0) chk("all_spacing", c - last, 5);
        last = c;
        g++;
      end
    end
    if (g < 5) chk("all_timeout", g, 5);
    req_valid = '0;
    repeat (4) @(negedge clk);
    exp_lookups = exp_lookups + 32'd5;
    chk("all_lookups", {32'd0, o_lookup_count}, {32'd0, exp_lookups});

    // Hit arriving only in the RESP cycle still counts.
    do_lookup(1, 32'h0A00_0101, 4, 1'b1, 1'b0);

    // Reset during WAIT: immediate clear, no response pulse.
    req_daddr[95:64] = 32'hC0A8_0005;
    req_valid[2] = 1'b1;
    @(negedge clk);
    chk("abort_ack", {60'd0, o_req_ack}, 64'd4);
    req_valid = '0;
    @(negedge clk);
    chk("abort_busy", {63'd0, o_busy}, 64'd1);
    reset = 1'b1;
    #1;
    chk("abort_busy0", {63'd0, o_busy}, 64'd0);
    chk("abort_daddr", {32'd0, o_lut_daddr}, 64'd0);
    chk("abort_cnt", {32'd0, o_lookup_count}, 64'd0);
    chk("abort_hits", {32'd0, o_local_hit_count}, 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    exp_lookups = 0;
    exp_hits = 0;
    @(negedge clk);
    do_lookup(1, 32'h0A00_0201, 2, 1'b1, 1'b0);

    // Counter wrap from all-ones.
    force dut.o_lookup_count = 32'hFFFF_FFFF;
    force dut.o_local_hit_count = 32'hFFFF_FFFF;
    #1;
    release dut.o_lookup_count;
    release dut.o_local_hit_count;
    exp_lookups = 32'hFFFF_FFFF;
    exp_hits = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("preset_cnt", {32'd0, o_lookup_count}, 64'hFFFF_FFFF);
    do_lookup(0, 32'h0A00_0300, 3, 1'b1, 1'b0);

    // Clear coinciding with the RESP increment, then clear alone.
    do_lookup(2, 32'h0A00_0302, 2, 1'b1, 1'b1);
    do_lookup(3, 32'h0A00_0303, 0, 1'b0, 1'b0);
    stats_clear = 1'b1;
    @(negedge clk);
    stats_clear = 1'b0;
    chk("clr_idle_lk", {32'd0, o_lookup_count}, 64'd0);
    chk("clr_idle_hit", {32'd0, o_local_hit_count}, 64'd0);

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
